// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the PC update logic and the instruction-memory
// responder, plus the array load/write port used by benches and boot code.
//
// Handshake: a fetch is accepted in a cycle where req & ready & ~flush & ~hlt.
// ready depends only on responder state, never on req, so the requester can
// look at ready before it commits to a request. instr_vld is a one-cycle
// pulse. instr and err are only meaningful while it is high.
//
// Signals:
//   req, addr        fetch request and byte address (PC value)
//   flush, hlt       branch-redirect cancel, halt (blocks acceptance)
//   ready            responder can accept a request this cycle
//   instr_vld        response pulse; instr/err valid with it
//   instr, err       fetched word, misaligned/out-of-range flag
//   busy             a fetch is in flight
//   we, waddr, wdata array write port (byte address, bit 0 ignored)
interface imem_fetch_responder_if;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic        hlt;
    logic        ready;
    logic        instr_vld;
    logic [15:0] instr;
    logic        err;
    logic        busy;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;

    modport master (
        output req, addr, flush, hlt, we, waddr, wdata,
        input  ready, instr_vld, instr, err, busy
    );

    modport slave (
        input  req, addr, flush, hlt, we, waddr, wdata,
        output ready, instr_vld, instr, err, busy
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder. It accepts a fetch address and returns the
// 16-bit word LATENCY cycles later. It back-pressures through ready and
// honours flush and halt. It also holds the word-addressed program array.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   bus        slave side of imem_fetch_responder_if (fetch + write port)
//   dbg_state  current FSM state (IDLE=0, WAIT=1, RESP=2) for observation
module imem_fetch_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    imem_fetch_responder_if.slave   bus,
    output logic [1:0]              dbg_state
);

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
    // WAIT covers cycles T+1 .. T+LATENCY-1, so it starts at LATENCY-2.
    localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        ready_int;
    logic        accept;

    logic [15:0] mem [DEPTH];
    logic [IW-1:0] rd_idx, wr_idx;
    logic        rd_fault;
    logic [15:0] rd_word;
    logic        wr_ok;

    logic [15:0] lat_instr;
    logic        lat_err;
    logic [15:0] instr_q;
    logic        err_q;

    logic        unused_waddr0;
    assign unused_waddr0 = bus.waddr[0];

    // Array read and fault detection for the current request address.
    assign rd_idx   = bus.addr[IW:1];
    assign wr_idx   = bus.waddr[IW:1];
    assign rd_fault = bus.addr[0] | ({1'b0, bus.addr[15:1]} >= DEPTH_W);
    assign rd_word  = rd_fault ? 16'h0000 : mem[rd_idx];
    assign wr_ok    = rst & bus.we & ({1'b0, bus.waddr[15:1]} < DEPTH_W);

    // The read above samples the pre-write word, so a same-cycle write and
    // fetch to one word returns the old data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_int  = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE:    ready_int = 1'b1;
            RESP:    ready_int = 1'b1;
            default: ready_int = 1'b0;
        endcase

        accept = ready_int & bus.req & ~bus.flush & ~bus.hlt;

        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                    cnt_next   = CNT_INIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output registers load only on entry to RESP, so instr holds the last
    // delivered word between pulses. With LATENCY=1 the response is loaded
    // straight from the array because acceptance and RESP entry coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_instr <= 16'h0000;
            lat_err   <= 1'b0;
            instr_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_instr <= rd_word;
                lat_err   <= rd_fault;
            end
            if (state_next == RESP) begin
                instr_q <= (LATENCY == 1) ? rd_word  : lat_instr;
                err_q   <= (LATENCY == 1) ? rd_fault : lat_err;
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.ready     = rst & ready_int;
    assign bus.instr_vld = rst & (state == RESP);
    assign bus.instr     = instr_q;
    assign bus.err       = rst & err_q;
    assign bus.busy      = rst & (state != IDLE);
    assign dbg_state     = state;

endmodule
